// File: rtl/button_event_decoder.sv
// Classifies debounced button press sequences as SINGLE/DOUBLE/LONG and presents them through
// a one-entry valid/ready register. Define BTN_EVT_REPEAT_EN for auto-repeat while held after LONG.
module button_event_decoder #(
  parameter int unsigned LONG_TICKS    = 50_000_000,
  parameter int unsigned DBL_GAP_TICKS = 25_000_000,
  parameter int unsigned REPEAT_TICKS  = 10_000_000,
  parameter int unsigned CNT_W         = 27
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       level_in,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ready,
  output logic       evt_dropped,
  output logic       busy
);

  typedef enum logic [2:0] {StArm, StIdle, StPress1, StGap, StHold} state_t;

  localparam logic [1:0] CodeRepeat = 2'b00;
  localparam logic [1:0] CodeSingle = 2'b01;
  localparam logic [1:0] CodeDouble = 2'b10;
  localparam logic [1:0] CodeLong   = 2'b11;

  localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] GapLast  = CNT_W'(DBL_GAP_TICKS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             emit;
  logic [1:0]       emit_code;
  logic             cnt_clr;

`ifdef BTN_EVT_REPEAT_EN
  localparam logic [CNT_W-1:0] RepLast = CNT_W'(REPEAT_TICKS - 1);
  // Set only while in a HOLD that was entered via LONG.
  logic rep_q;
`else
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_TICKS;
`endif

  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    emit_code = CodeRepeat;
    cnt_clr   = 1'b0;
    unique case (state_q)
      StArm: begin
        if (!level_in) state_d = StIdle;
      end
      StIdle: begin
        if (level_in) state_d = StPress1;
      end
      StPress1: begin
        if (!level_in) begin
          state_d = StGap;
        end else if (cnt_q == LongLast) begin
          emit      = 1'b1;
          emit_code = CodeLong;
          state_d   = StHold;
        end
      end
      StGap: begin
        if (level_in) begin
          emit      = 1'b1;
          emit_code = CodeDouble;
          state_d   = StHold;
        end else if (cnt_q == GapLast) begin
          emit      = 1'b1;
          emit_code = CodeSingle;
          state_d   = StIdle;
        end
      end
      StHold: begin
        if (!level_in) begin
          state_d = StIdle;
`ifdef BTN_EVT_REPEAT_EN
        end else if (rep_q && (cnt_q == RepLast)) begin
          emit      = 1'b1;
          emit_code = CodeRepeat;
          cnt_clr   = 1'b1;
`endif
        end
      end
      default: state_d = StArm;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StArm;
      cnt_q       <= '0;
      evt_valid   <= 1'b0;
      evt_code    <= 2'b00;
      evt_dropped <= 1'b0;
      busy        <= 1'b0;
`ifdef BTN_EVT_REPEAT_EN
      rep_q       <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if ((state_d != state_q) || cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
      busy <= (state_d == StPress1) || (state_d == StGap) || (state_d == StHold);
`ifdef BTN_EVT_REPEAT_EN
      if (state_d != state_q) rep_q <= (state_q == StPress1) && (state_d == StHold);
`endif
      // A full, unaccepted register keeps its event; the new one is dropped.
      evt_dropped <= 1'b0;
      if (emit) begin
        if (evt_valid && !evt_ready) begin
          evt_dropped <= 1'b1;
        end else begin
          evt_valid <= 1'b1;
          evt_code  <= emit_code;
        end
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder: scenario table, hand-written corner sequences
// and randomized stimulus compared every cycle against a timestamp-based reference model.
module tb_button_event_decoder;

  localparam int LongT = 20;
  localparam int GapT  = 10;
  localparam int RepT  = 8;

  localparam int PhArm   = 0;
  localparam int PhIdle  = 1;
  localparam int PhPress = 2;
  localparam int PhGap   = 3;
  localparam int PhHold  = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       level_in;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready;
  logic       evt_dropped;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  button_event_decoder #(
    .LONG_TICKS   (LongT),
    .DBL_GAP_TICKS(GapT),
    .REPEAT_TICKS (RepT),
    .CNT_W        (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .level_in   (level_in),
    .evt_valid  (evt_valid),
    .evt_code   (evt_code),
    .evt_ready  (evt_ready),
    .evt_dropped(evt_dropped),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phases with absolute edge timestamps rather than a counter.
  typedef struct packed {
    int         phase;
    int         t_start;
    int         e;
    bit         via_long;
    bit         started;
    logic       valid;
    logic [1:0] code;
    logic       drop;
    logic       busy;
  } model_t;

  model_t m = '0;

  function automatic model_t step(model_t cur, logic rst, logic lvl, logic rdy);
    model_t     o;
    bit         emit;
    logic [1:0] c;
    int         e;
    o    = cur;
    emit = 1'b0;
    c    = 2'b00;
    e    = cur.e + 1;
    o.e  = e;
    if (rst) begin
      o.phase    = PhArm;
      o.t_start  = e;
      o.via_long = 1'b0;
      o.started  = 1'b1;
      o.valid    = 1'b0;
      o.code     = 2'b00;
      o.drop     = 1'b0;
      o.busy     = 1'b0;
      return o;
    end
    case (cur.phase)
      PhArm:   if (!lvl) o.phase = PhIdle;
      PhIdle:  if (lvl) begin o.phase = PhPress; o.t_start = e; end
      PhPress: begin
        if (!lvl) begin
          o.phase = PhGap; o.t_start = e;
        end else if (e - cur.t_start == LongT) begin
          emit = 1'b1; c = 2'b11; o.phase = PhHold; o.t_start = e; o.via_long = 1'b1;
        end
      end
      PhGap: begin
        if (lvl) begin
          emit = 1'b1; c = 2'b10; o.phase = PhHold; o.t_start = e; o.via_long = 1'b0;
        end else if (e - cur.t_start == GapT) begin
          emit = 1'b1; c = 2'b01; o.phase = PhIdle; o.t_start = e;
        end
      end
      PhHold: begin
        if (!lvl) begin
          o.phase = PhIdle; o.t_start = e;
`ifdef BTN_EVT_REPEAT_EN
        end else if (cur.via_long && (e - cur.t_start == RepT)) begin
          emit = 1'b1; c = 2'b00; o.t_start = e;
`endif
        end
      end
      default: o.phase = PhArm;
    endcase
    o.drop = 1'b0;
    if (emit) begin
      if (cur.valid && !rdy) o.drop = 1'b1;
      else begin o.valid = 1'b1; o.code = c; end
    end else if (cur.valid && rdy) begin
      o.valid = 1'b0;
    end
    o.busy = (o.phase == PhPress) || (o.phase == PhGap) || (o.phase == PhHold);
    return o;
  endfunction

  always @(posedge clock) m <= step(m, reset, level_in, evt_ready);

  always @(negedge clock) begin
    if (m.started) begin
      check("model evt_valid", 32'(evt_valid), 32'(m.valid));
      check("model evt_code", 32'(evt_code), 32'(m.code));
      check("model evt_dropped", 32'(evt_dropped), 32'(m.drop));
      check("model busy", 32'(busy), 32'(m.busy));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scenario: high hi1 edges, low gap edges, high hi2 edges, then low.
  // first_edge counts edges from the one that samples the first rise (edge 1).
  typedef struct packed {
    int         hi1;
    int         gap;
    int         hi2;
    logic [1:0] code;
    int         first_edge;
    int         n_evt;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int         cnt;
    int         drops;
    int         first_e;
    logic [1:0] first_c;
    int         run_left;

    tbl[0] = '{hi1: 5,  gap: 0,  hi2: 0,  code: 2'b01, first_edge: 16, n_evt: 1};
    tbl[1] = '{hi1: 5,  gap: 4,  hi2: 6,  code: 2'b10, first_edge: 10, n_evt: 1};
    tbl[2] = '{hi1: 25, gap: 0,  hi2: 0,  code: 2'b11, first_edge: 21, n_evt: 1};
    tbl[3] = '{hi1: 1,  gap: 0,  hi2: 0,  code: 2'b01, first_edge: 12, n_evt: 1};
    tbl[4] = '{hi1: 20, gap: 0,  hi2: 0,  code: 2'b01, first_edge: 31, n_evt: 1};
    tbl[5] = '{hi1: 21, gap: 0,  hi2: 0,  code: 2'b11, first_edge: 21, n_evt: 1};
    tbl[6] = '{hi1: 5,  gap: 10, hi2: 3,  code: 2'b10, first_edge: 16, n_evt: 1};
    tbl[7] = '{hi1: 5,  gap: 11, hi2: 3,  code: 2'b01, first_edge: 16, n_evt: 2};
    tbl[8] = '{hi1: 5,  gap: 4,  hi2: 30, code: 2'b10, first_edge: 10, n_evt: 1};
    tbl[9] = '{hi1: 3,  gap: 1,  hi2: 1,  code: 2'b10, first_edge: 5,  n_evt: 1};

    reset     = 1'b1;
    level_in  = 1'b0;
    evt_ready = 1'b1;
    repeat (3) tick();
    check("reset evt_valid", 32'(evt_valid), 32'd0);
    check("reset evt_code", 32'(evt_code), 32'd0);
    check("reset busy", 32'(busy), 32'd0);

    // Button held through reset: ARM must swallow it.
    level_in = 1'b1;
    cnt      = 0;
    repeat (30) begin tick(); cnt += int'(evt_valid | busy | evt_dropped); end
    reset = 1'b0;
    repeat (30) begin tick(); cnt += int'(evt_valid | busy | evt_dropped); end
    level_in = 1'b0;
    repeat (15) begin tick(); cnt += int'(evt_valid | busy | evt_dropped); end
    check("held at reset quiet", 32'(cnt), 32'd0);

    foreach (tbl[i]) begin
      level_in  = 1'b0;
      evt_ready = 1'b1;
      repeat (15) tick();
      cnt     = 0;
      drops   = 0;
      first_e = -1;
      first_c = 2'bxx;
      for (int e = 1; e <= tbl[i].hi1 + tbl[i].gap + tbl[i].hi2 + 45; e++) begin
        level_in = (e <= tbl[i].hi1) ||
                   ((tbl[i].hi2 > 0) && (e > tbl[i].hi1 + tbl[i].gap) &&
                    (e <= tbl[i].hi1 + tbl[i].gap + tbl[i].hi2));
        tick();
        drops += int'(evt_dropped);
        if (evt_valid) begin
          cnt++;
          if (first_e < 0) begin first_e = e; first_c = evt_code; end
        end
      end
      check($sformatf("tbl%0d code", i), 32'(first_c), 32'(tbl[i].code));
      check($sformatf("tbl%0d edge", i), 32'(first_e), 32'(tbl[i].first_edge));
      check($sformatf("tbl%0d count", i), 32'(cnt), 32'(tbl[i].n_evt));
      check($sformatf("tbl%0d drops", i), 32'(drops), 32'd0);
    end

    // Consumer stalled: SINGLE stays, the following LONG is dropped once.
    level_in  = 1'b0;
    evt_ready = 1'b0;
    repeat (5) tick();
    drops = 0;
    level_in = 1'b1;
    repeat (5) begin tick(); drops += int'(evt_dropped); end
    level_in = 1'b0;
    repeat (15) begin tick(); drops += int'(evt_dropped); end
    level_in = 1'b1;
    repeat (25) begin tick(); drops += int'(evt_dropped); end
    level_in = 1'b0;
    repeat (5) begin tick(); drops += int'(evt_dropped); end
    check("stall drops", 32'(drops), 32'd1);
    check("stall code", 32'(evt_code), 32'd1);
    check("stall valid", 32'(evt_valid), 32'd1);
    evt_ready = 1'b1;
    tick();
    check("stall release valid", 32'(evt_valid), 32'd0);

    // Reset mid-press abandons the sequence.
    repeat (5) tick();
    level_in = 1'b1;
    repeat (4) tick();
    check("mid-press busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    check("mid-press reset busy", 32'(busy), 32'd0);
    reset = 1'b0;
    cnt   = 0;
    repeat (3) begin tick(); cnt += int'(evt_valid | busy); end
    level_in = 1'b0;
    repeat (30) begin tick(); cnt += int'(evt_valid | busy); end
    check("mid-press quiet", 32'(cnt), 32'd0);
    cnt     = 0;
    first_c = 2'bxx;
    level_in = 1'b1;
    repeat (5) tick();
    level_in = 1'b0;
    repeat (20) begin
      tick();
      if (evt_valid) begin cnt++; first_c = evt_code; end
    end
    check("post-reset click count", 32'(cnt), 32'd1);
    check("post-reset click code", 32'(first_c), 32'd1);

    // Randomized traffic, checked by the model every cycle.
    run_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (run_left == 0) begin
        level_in = ~level_in;
        run_left = $urandom_range(1, 30);
      end
      run_left--;
      evt_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
